ndev_debug_decoder: RTL

- Upstream stage of the UART byte queue. Samples the 8-bit NDEV_LED debug bus from the console and classifies each new bus value.
- Raw mode: emits every changed bus value as a byte. Serial mode: reassembles the bit-serial protocol into bytes.
- Output bytes go through an internal FIFO with a valid/ready handshake to the UART transmitter feeder.
- Also produces the sticky "win" flag that inhibits further reset pulses.

---
 rtl/ndev_debug_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ndev_debug_decoder.sv
// ndev_debug_decoder: samples the NDEV_LED debug bus, decodes raw or bit-serial
// traffic into bytes, queues them in an output FIFO and tracks the sticky win flag.
// Optional glitch filter on the synchronized bus: define NDEV_GLITCH_FILTER_EN.
module ndev_debug_decoder #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] dbg_in,
  input  logic       hold,
  input  logic       snap,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       win,
  output logic       serial_mode,
  output logic [7:0] drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Reject FIFO depths that are not a power of two and a zero filter length
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || FILTER_CYCLES < 1) begin : g_param_err
    $error("ndev_debug_decoder: DEPTH must be a power of 2 >= 2, FILTER_CYCLES >= 1");
  end

  logic [7:0] sync1, sync2, cur;

  // Two-flop synchronizer; reset to the idle 'last' value so reset exit is quiet
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 8'h55;
      sync2 <= 8'h55;
    end else begin
      sync1 <= dbg_in;
      sync2 <= sync1;
    end
  end

`ifdef NDEV_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
  logic [7:0]    cand;
  logic [CW-1:0] stab;

  // cur follows the synchronizer only after FILTER_CYCLES cycles of a steady value
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand <= 8'h55;
      stab <= '0;
      cur  <= 8'h55;
    end else if (sync2 != cand) begin
      cand <= sync2;
      stab <= CW'(1);
    end else begin
      if (stab < CW'(FILTER_CYCLES)) stab <= stab + CW'(1);
      if (stab == CW'(FILTER_CYCLES)) cur <= cand;
    end
  end
`else
  assign cur = sync2;
`endif

  logic [7:0] last, last_n;
  logic [7:0] shift, shift_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic       win_n, serial_n;
  logic       push;
  logic [7:0] push_data;
  logic       change;

  // Decoder next-state: raw capture, serial reassembly, hold clearing
  always_comb begin
    last_n    = last;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    win_n     = win;
    serial_n  = serial_mode;
    push      = 1'b0;
    push_data = cur;
    change    = (cur != last) && !hold;
    if (hold) begin
      serial_n  = 1'b0;
      win_n     = 1'b0;
      shift_n   = 8'h00;
      bit_cnt_n = 4'd0;
    end else if (!serial_mode) begin
      if (change) last_n = cur;
      if (change || snap) begin
        push = 1'b1;
        if (cur == 8'h88 || cur == 8'h25) begin
          win_n = 1'b1;
        end else if (cur == 8'hC3 || cur == 8'hDA || cur == 8'hE1 ||
                     cur == 8'h0D || cur == 8'h1D) begin
          win_n = 1'b0;
        end
        if (cur == 8'h8F && last == 8'h0F) serial_n = 1'b1;
      end
    end else if (change) begin
      last_n = cur;
      if (cur == 8'h8F) begin
        if (bit_cnt == 4'd8) begin
          push      = 1'b1;
          push_data = shift;
        end
        shift_n   = 8'h00;
        bit_cnt_n = 4'd0;
      end else if (cur[7] && !last[7] && (cur & 8'h7E) == 8'h00 && bit_cnt <= 4'd7) begin
        shift_n   = {shift[6:0], cur[0]};
        bit_cnt_n = bit_cnt + 4'd1;
      end
    end
  end

  // Decoder state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last        <= 8'h55;
      shift       <= 8'h00;
      bit_cnt     <= 4'd0;
      win         <= 1'b0;
      serial_mode <= 1'b0;
    end else begin
      last        <= last_n;
      shift       <= shift_n;
      bit_cnt     <= bit_cnt_n;
      win         <= win_n;
      serial_mode <= serial_n;
    end
  end

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          empty, full, pop, accept;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign accept    = push && (!full || pop);
  assign out_data  = out_valid ? mem[rptr[AW-1:0]] : 8'h00;

  // FIFO storage write
  always_ff @(posedge CLK) begin
    if (accept) mem[wptr[AW-1:0]] <= push_data;
  end

  // FIFO pointers and saturating drop counter
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr     <= '0;
      rptr     <= '0;
      drop_cnt <= 8'h00;
    end else begin
      if (accept) wptr <= wptr + PW'(1);
      if (pop)    rptr <= rptr + PW'(1);
      if (push && !accept && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
